// File: rtl/cia_bus_target.sv
// CIA-style register target: filters the synchronized E clock and turns each
// chip-selected E cycle into a single write or read strobe toward the register file.
module cia_bus_target #(
  parameter int unsigned E_FILT  = 2,
  parameter int unsigned OE_HOLD = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                _reset,
  input  logic                reg_sel,
  input  logic                r_w,
  input  logic                _cs,
  input  logic                e,
  input  logic [7:0]          data_in,
  output logic                wr_strobe,
  output logic                wr_sel,
  output logic [7:0]          wr_data,
  output logic                rd_strobe,
  output logic                rd_sel,
  input  logic [7:0]          rd_data,
  output logic [7:0]          data_out,
  output logic                data_oe,
  output logic                err_abort,
  output logic                err_timeout
);

  localparam int unsigned DW  = 8;
  localparam int unsigned FCW = 4;
  localparam int unsigned HCW = 4;
  localparam int unsigned TCW = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    READ   = 3'd2,
    HOLD   = 3'd3,
    WRITE  = 3'd4
  } state_t;

  state_t           state, state_d;
  logic             e_filt;
  logic [FCW-1:0]   filt_cnt;
  logic             armed;
  logic             sel, sel_d;
  logic [TCW-1:0]   tmo_cnt, tmo_d;
  logic [HCW-1:0]   hold_cnt, hold_d;
  logic [DW-1:0]    data_out_d, wr_data_d;
  logic             data_oe_d, wr_sel_d, wr_strobe_d, rd_sel_d, rd_strobe_d;
  logic             err_abort_d, err_timeout_d;

  logic e_diff_c, e_tog_c, e_rise_c, e_fall_c, tmo_hit_c;

  // A rise only counts once E has been seen low since reset, so an E that is
  // already high when reset releases cannot start a cycle.
  assign e_diff_c  = e ^ e_filt;
  assign e_tog_c   = e_diff_c && (filt_cnt == FCW'(E_FILT - 1));
  assign e_rise_c  = e_tog_c && e && armed;
  assign e_fall_c  = e_tog_c && !e;
  assign tmo_hit_c = (tmo_cnt == TCW'(TIMEOUT - 1));

  // E glitch filter
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      e_filt   <= 1'b0;
      filt_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      if (!e_diff_c) begin
        filt_cnt <= '0;
      end else if (e_tog_c) begin
        filt_cnt <= '0;
        e_filt   <= ~e_filt;
      end else begin
        filt_cnt <= filt_cnt + FCW'(1);
      end
      if (!e_filt && !e) begin
        armed <= 1'b1;
      end
    end
  end

  // Bus cycle state and registered outputs
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state       <= IDLE;
      sel         <= 1'b0;
      tmo_cnt     <= '0;
      hold_cnt    <= '0;
      data_out    <= '0;
      data_oe     <= 1'b0;
      wr_data     <= '0;
      wr_sel      <= 1'b0;
      wr_strobe   <= 1'b0;
      rd_sel      <= 1'b0;
      rd_strobe   <= 1'b0;
      err_abort   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      sel         <= sel_d;
      tmo_cnt     <= tmo_d;
      hold_cnt    <= hold_d;
      data_out    <= data_out_d;
      data_oe     <= data_oe_d;
      wr_data     <= wr_data_d;
      wr_sel      <= wr_sel_d;
      wr_strobe   <= wr_strobe_d;
      rd_sel      <= rd_sel_d;
      rd_strobe   <= rd_strobe_d;
      err_abort   <= err_abort_d;
      err_timeout <= err_timeout_d;
    end
  end

  // Next state: E fall beats _cs release, which beats timeout
  always_comb begin
    state_d       = state;
    sel_d         = sel;
    tmo_d         = tmo_cnt;
    hold_d        = hold_cnt;
    data_out_d    = data_out;
    data_oe_d     = data_oe;
    wr_data_d     = wr_data;
    wr_sel_d      = wr_sel;
    wr_strobe_d   = 1'b0;
    rd_sel_d      = rd_sel;
    rd_strobe_d   = 1'b0;
    err_abort_d   = 1'b0;
    err_timeout_d = 1'b0;

    case (state)
      IDLE: begin
        if (e_rise_c && !_cs) begin
          sel_d = reg_sel;
          tmo_d = '0;
          if (r_w) begin
            state_d     = RD_REQ;
            rd_strobe_d = 1'b1;
            rd_sel_d    = reg_sel;
          end else begin
            state_d = WRITE;
          end
        end
      end

      RD_REQ: begin
        tmo_d = tmo_cnt + TCW'(1);
        if (e_fall_c) begin
          state_d = IDLE;
        end else if (_cs) begin
          err_abort_d = 1'b1;
          state_d     = IDLE;
        end else if (tmo_hit_c) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          state_d = READ;
        end
      end

      READ: begin
        tmo_d = tmo_cnt + TCW'(1);
        // data_oe low here only on the entry clk, so read data is captured once
        if (!data_oe) begin
          data_out_d = rd_data;
          data_oe_d  = 1'b1;
        end
        if (e_fall_c) begin
          state_d = HOLD;
          hold_d  = '0;
        end else if (_cs) begin
          err_abort_d = 1'b1;
          data_oe_d   = 1'b0;
          state_d     = IDLE;
        end else if (tmo_hit_c) begin
          err_timeout_d = 1'b1;
          data_oe_d     = 1'b0;
          state_d       = IDLE;
        end
      end

      HOLD: begin
        if (hold_cnt == HCW'(OE_HOLD)) begin
          data_oe_d = 1'b0;
          state_d   = IDLE;
        end else begin
          hold_d = hold_cnt + HCW'(1);
        end
      end

      WRITE: begin
        tmo_d = tmo_cnt + TCW'(1);
        if (e_fall_c) begin
          wr_data_d   = data_in;
          wr_sel_d    = sel;
          wr_strobe_d = 1'b1;
          state_d     = IDLE;
        end else if (_cs) begin
          err_abort_d = 1'b1;
          state_d     = IDLE;
        end else if (tmo_hit_c) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        data_oe_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cia_bus_target.sv
// Directed bench for cia_bus_target: vector table of whole bus cycles plus
// hand-timed sequences for latency, abort, timeout and reset corners.
module tb_cia_bus_target;

  logic       clk = 1'b0;
  logic       _reset;
  logic       reg_sel, r_w, _cs, e;
  logic [7:0] data_in, rd_data;
  logic       wr_strobe, wr_sel, rd_strobe, rd_sel, data_oe, err_abort, err_timeout;
  logic [7:0] wr_data, data_out;

  int total = 0;
  int bad = 0;
  int both_cnt = 0;

  cia_bus_target #(.E_FILT(2), .OE_HOLD(2), .TIMEOUT(255)) dut (
    .clk(clk), ._reset(_reset), .reg_sel(reg_sel), .r_w(r_w), ._cs(_cs), .e(e),
    .data_in(data_in), .wr_strobe(wr_strobe), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_strobe(rd_strobe), .rd_sel(rd_sel), .rd_data(rd_data), .data_out(data_out),
    .data_oe(data_oe), .err_abort(err_abort), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       cs_n;
    logic       sel;
    logic       rw;
    logic [7:0] din;
    logic [7:0] rdd;
    logic [7:0] ehigh;
    logic [1:0] exp_wr;
    logic [1:0] exp_rd;
    logic       exp_wsel;
    logic [7:0] exp_wdata;
    logic       exp_rsel;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (wr_strobe && rd_strobe) both_cnt++;
  endtask

  // One full E cycle: E high for ehigh clks, then low long enough to finish HOLD.
  task automatic run_cycle(input vec_t v, input int idx);
    int wcnt = 0, rcnt = 0;
    logic ws = 1'b0, rs = 1'b0, oe_seen = 1'b0;
    logic [7:0] dseen = 8'h00;
    _cs = v.cs_n; reg_sel = v.sel; r_w = v.rw; data_in = v.din; rd_data = v.rdd;
    for (int i = 0; i < 8 + int'(v.ehigh); i++) begin
      e = (i < int'(v.ehigh));
      step();
      if (wr_strobe) begin wcnt++; ws = wr_sel; end
      if (rd_strobe) begin rcnt++; rs = rd_sel; end
      if (data_oe) begin oe_seen = 1'b1; dseen = data_out; end
    end
    _cs = 1'b1;
    chk($sformatf("vec%0d_wr_count", idx), wcnt, 32'(v.exp_wr));
    chk($sformatf("vec%0d_rd_count", idx), rcnt, 32'(v.exp_rd));
    chk($sformatf("vec%0d_wr_data", idx), wr_data, v.exp_wdata);
    chk($sformatf("vec%0d_oe_seen", idx), oe_seen, (v.exp_rd != 2'd0));
    if (v.exp_wr != 2'd0) chk($sformatf("vec%0d_wr_sel", idx), ws, v.exp_wsel);
    if (v.exp_rd != 2'd0) begin
      chk($sformatf("vec%0d_rd_sel", idx), rs, v.exp_rsel);
      chk($sformatf("vec%0d_data_out", idx), dseen, v.exp_dout);
    end
  endtask

  initial begin
    int cnt_a, cnt_b, to_at, to_cnt;
    logic to_oe;
    vec_t v;
    //           cs sel rw  din    rdd    eh  wr rd wsel wdata  rsel dout
    vecs[0] = '{1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 8'd10, 2'd1, 2'd0, 1'b1, 8'hA5, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h3C, 8'd10, 2'd0, 2'd1, 1'b0, 8'hA5, 1'b0, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 8'd10, 2'd1, 2'd0, 1'b0, 8'h5A, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hC3, 8'd3,  2'd0, 2'd1, 1'b0, 8'h5A, 1'b1, 8'hC3};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'd1,  2'd0, 2'd0, 1'b0, 8'h5A, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h99, 8'h00, 8'd10, 2'd0, 2'd0, 1'b0, 8'h5A, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h11, 8'h00, 8'd2,  2'd1, 2'd0, 1'b1, 8'h11, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h77, 8'd1,  2'd0, 2'd0, 1'b0, 8'h11, 1'b0, 8'h00};

    _reset = 1'b0; reg_sel = 1'b0; r_w = 1'b0; _cs = 1'b1; e = 1'b0;
    data_in = 8'h00; rd_data = 8'h00;
    #3;
    chk("reset_outputs", {wr_strobe, wr_sel, wr_data, rd_strobe, rd_sel, data_out,
                          data_oe, err_abort, err_timeout}, 32'h0);
    repeat (2) @(posedge clk);
    #1 _reset = 1'b1;
    repeat (3) step();

    for (int i = 0; i < 8; i++) run_cycle(vecs[i], i);

    // Read latency, single capture and OE hold
    _cs = 1'b0; r_w = 1'b1; reg_sel = 1'b0; rd_data = 8'h3C; e = 1'b1;
    step(); chk("rd_lat_p1", rd_strobe, 1'b0);
    step(); chk("rd_lat_p2", {rd_strobe, rd_sel}, 2'b10);
    step(); chk("rd_lat_p3", {rd_strobe, data_oe}, 2'b00);
    step(); chk("rd_cap_p4", {data_oe, data_out}, {1'b1, 8'h3C});
    rd_data = 8'hFF;
    repeat (6) step();
    chk("rd_cap_once", data_out, 8'h3C);
    e = 1'b0;
    step(); step(); chk("rd_oe_fall", data_oe, 1'b1);
    step(); step(); chk("rd_oe_hold2", data_oe, 1'b1);
    step(); chk("rd_oe_drop", data_oe, 1'b0);
    _cs = 1'b1; repeat (3) step();

    // Write latency relative to filtered fall
    _cs = 1'b0; r_w = 1'b0; reg_sel = 1'b1; data_in = 8'hA5; e = 1'b1;
    repeat (10) step();
    e = 1'b0;
    step(); chk("wr_lat_early", wr_strobe, 1'b0);
    step(); chk("wr_lat_pulse", {wr_strobe, wr_sel, wr_data}, {2'b11, 8'hA5});
    step(); chk("wr_lat_one_clk", wr_strobe, 1'b0);
    _cs = 1'b1; repeat (3) step();

    // Write abort, then a normal write
    _cs = 1'b0; r_w = 1'b0; reg_sel = 1'b0; data_in = 8'h77; e = 1'b1;
    repeat (5) step();
    _cs = 1'b1;
    step(); chk("wabort_pulse", {err_abort, wr_strobe}, 2'b10);
    step(); chk("wabort_one_clk", err_abort, 1'b0);
    e = 1'b0; cnt_a = 0;
    repeat (6) begin step(); if (wr_strobe) cnt_a++; end
    chk("wabort_no_strobe", cnt_a, 0);
    chk("wabort_wr_data_held", wr_data, 8'hA5);
    v = '{1'b0, 1'b1, 1'b0, 8'h42, 8'h00, 8'd10, 2'd1, 2'd0, 1'b1, 8'h42, 1'b0, 8'h00};
    run_cycle(v, 100);

    // Read abort drops data_oe
    _cs = 1'b0; r_w = 1'b1; reg_sel = 1'b1; rd_data = 8'h5C; e = 1'b1;
    repeat (4) step();
    chk("rabort_oe_before", data_oe, 1'b1);
    _cs = 1'b1;
    step(); chk("rabort_pulse", {err_abort, data_oe}, 2'b10);
    e = 1'b0; repeat (6) step();

    // _cs release on the same clk as the filtered fall: cycle completes
    _cs = 1'b0; r_w = 1'b0; reg_sel = 1'b0; data_in = 8'hC9; e = 1'b1;
    repeat (10) step();
    e = 1'b0;
    step();
    _cs = 1'b1;
    step(); chk("cs_fall_same_clk", {wr_strobe, err_abort, wr_data}, {2'b10, 8'hC9});
    repeat (4) step();

    // Timeout on a read with E held high for 300 clks
    _cs = 1'b0; r_w = 1'b1; reg_sel = 1'b0; rd_data = 8'h12; e = 1'b1;
    to_at = 0; to_cnt = 0; to_oe = 1'b1; cnt_a = 0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (rd_strobe) cnt_a++;
      if (err_timeout) begin
        to_cnt++;
        if (to_at == 0) begin to_at = k; to_oe = data_oe; end
      end
    end
    chk("tmo_clk", to_at, 257);
    chk("tmo_pulses", to_cnt, 1);
    chk("tmo_oe", to_oe, 1'b0);
    chk("tmo_rd_count", cnt_a, 1);
    e = 1'b0; cnt_b = 0;
    repeat (10) begin step(); if (rd_strobe || wr_strobe) cnt_b++; end
    chk("tmo_no_late_strobe", cnt_b, 0);
    _cs = 1'b1; repeat (2) step();

    // Reset mid-read, release with E still high
    _cs = 1'b0; r_w = 1'b1; reg_sel = 1'b0; rd_data = 8'hAB; e = 1'b1;
    repeat (4) step();
    chk("rst_oe_before", data_oe, 1'b1);
    #2 _reset = 1'b0;
    #1 chk("rst_async_outputs", {data_oe, data_out, rd_strobe}, 32'h0);
    repeat (2) @(posedge clk);
    #1 _reset = 1'b1;
    cnt_a = 0;
    repeat (10) begin step(); if (rd_strobe) cnt_a++; end
    chk("rst_no_rise_high_e", cnt_a, 0);
    e = 1'b0;
    repeat (5) step();
    e = 1'b1; cnt_b = 0;
    repeat (6) begin step(); if (rd_strobe) cnt_b++; end
    chk("rst_fresh_rise", cnt_b, 1);
    e = 1'b0; _cs = 1'b1;
    repeat (8) step();

    chk("no_dual_strobe", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
